// File: rtl/rhythm_pkg.sv
// Shared rhythm-game definitions: judgement encoding, judge FSM states and combo limit.
// The score counter imports the same judge constants so both ends agree on the code.
package rhythm_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_EARLY   = 2'b01;
  localparam logic [1:0] JUDGE_LATE    = 2'b10;
  localparam logic [1:0] JUDGE_PERFECT = 2'b11;

  localparam int COMBO_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EARLY   = 2'd1,
    ST_PERFECT = 2'd2,
    ST_LATE    = 2'd3
  } state_t;

  function automatic logic [7:0] combo_inc(input logic [7:0] v);
    return (v == 8'(COMBO_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one player button.
// press goes high for one clk, three clk after a clean rising edge on btn_raw.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      sync2_d <= sync2;
      press   <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Grades one note lane against the player's button: early-good, perfect, late-good or miss,
// and keeps the running and best combo for the score counter.
module hit_judge
  import rhythm_pkg::*;
#(
  parameter int EARLY_TICKS   = 2,
  parameter int PERFECT_TICKS = 2,
  parameter int LATE_TICKS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       note_arrive,
  input  logic       btn_raw,
  output logic [1:0] judge,
  output logic       miss,
  output logic [7:0] combo,
  output logic [7:0] max_combo,
  output logic       window_open,
  output state_t     state_dbg
);

  // judge/miss form a valid-only interface: a non-zero judge or miss=1 is valid for
  // exactly one clk and there is no ready; the score counter samples on the next edge.

  logic       press;
  state_t     state, state_n;
  logic [7:0] zcnt, zcnt_n;
  logic [1:0] judge_n;
  logic       miss_n, hit;
  logic [7:0] combo_n, max_n;
  logic       zone_expire;

  btn_sync_edge u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .press   (press)
  );

  assign zone_expire = tick && (zcnt == 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      zcnt  <= 8'd0;
    end else begin
      state <= state_n;
      zcnt  <= zcnt_n;
    end
  end

  // A new note always restarts the window; the old one is graded in the output logic.
  always_comb begin
    state_n = state;
    zcnt_n  = zcnt;
    if (note_arrive) begin
      state_n = ST_EARLY;
      zcnt_n  = 8'(EARLY_TICKS);
    end else if (state != ST_IDLE) begin
      if (press) begin
        state_n = ST_IDLE;
        zcnt_n  = 8'd0;
      end else if (zone_expire) begin
        case (state)
          ST_EARLY: begin
            state_n = ST_PERFECT;
            zcnt_n  = 8'(PERFECT_TICKS);
          end
          ST_PERFECT: begin
            state_n = ST_LATE;
            zcnt_n  = 8'(LATE_TICKS);
          end
          default: begin
            state_n = ST_IDLE;
            zcnt_n  = 8'd0;
          end
        endcase
      end else if (tick) begin
        zcnt_n = zcnt - 8'd1;
      end
    end
  end

  always_comb begin
    judge_n = JUDGE_NONE;
    miss_n  = 1'b0;
    hit     = 1'b0;
    if (state != ST_IDLE) begin
      if (press) begin
        hit = 1'b1;
        case (state)
          ST_EARLY:   judge_n = JUDGE_EARLY;
          ST_PERFECT: judge_n = JUDGE_PERFECT;
          default:    judge_n = JUDGE_LATE;
        endcase
      end else if (note_arrive || (zone_expire && state == ST_LATE)) begin
        miss_n = 1'b1;
      end
    end
    combo_n = hit ? combo_inc(combo) : (miss_n ? 8'd0 : combo);
    max_n   = (combo_n > max_combo) ? combo_n : max_combo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      judge     <= JUDGE_NONE;
      miss      <= 1'b0;
      combo     <= 8'd0;
      max_combo <= 8'd0;
    end else begin
      judge     <= judge_n;
      miss      <= miss_n;
      combo     <= combo_n;
      max_combo <= max_n;
    end
  end

  assign window_open = (state != ST_IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with default zone lengths (2/2/2 ticks).
module tb_hit_judge;
  import rhythm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       note_arrive = 1'b0;
  logic       btn_raw = 1'b0;
  logic [1:0] judge;
  logic       miss;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic       window_open;
  state_t     state_dbg;

  int vecs = 0;
  int errs = 0;

  hit_judge dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .note_arrive (note_arrive),
    .btn_raw     (btn_raw),
    .judge       (judge),
    .miss        (miss),
    .combo       (combo),
    .max_combo   (max_combo),
    .window_open (window_open),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // ---- driver tasks: every step ends 1 time unit after a rising edge ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0;
    note_arrive = 1'b0;
    btn_raw = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic send_note();
    note_arrive = 1'b1;
    cyc();
    note_arrive = 1'b0;
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // Button rises; returns outputs in the grading cycle and the cycle after, then releases.
  task automatic press_btn(output logic [1:0] j, output logic m, output logic [1:0] j_next);
    btn_raw = 1'b1;
    repeat (4) cyc();
    j = judge;
    m = miss;
    btn_raw = 1'b0;
    cyc();
    j_next = judge;
    repeat (2) cyc();
  endtask

  task automatic perfect_hit();
    logic [1:0] j, jn;
    logic m;
    send_note();
    send_ticks(2);
    press_btn(j, m, jn);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    #2;
    vecs++; if (judge !== 2'b00) begin errs++; $display("FAIL reset_judge: got %b want 00", judge); end
    vecs++; if (miss !== 1'b0) begin errs++; $display("FAIL reset_miss: got %b want 0", miss); end
    vecs++; if (combo !== 8'd0) begin errs++; $display("FAIL reset_combo: got %0d want 0", combo); end
    vecs++; if (max_combo !== 8'd0) begin errs++; $display("FAIL reset_max: got %0d want 0", max_combo); end
    vecs++; if (window_open !== 1'b0) begin errs++; $display("FAIL reset_window: got %b want 0", window_open); end
    do_reset();
  endtask

  task automatic test_perfect();
    logic [1:0] j, jn;
    logic m;
    do_reset();
    send_note();
    vecs++; if (window_open !== 1'b1) begin errs++; $display("FAIL perf_window_rise: got %b want 1", window_open); end
    vecs++; if (state_dbg !== ST_EARLY) begin errs++; $display("FAIL perf_state_early: got %0d want %0d", state_dbg, ST_EARLY); end
    send_ticks(2);
    vecs++; if (state_dbg !== ST_PERFECT) begin errs++; $display("FAIL perf_state_perfect: got %0d want %0d", state_dbg, ST_PERFECT); end
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b11) begin errs++; $display("FAIL perf_judge: got %b want 11", j); end
    vecs++; if (m !== 1'b0) begin errs++; $display("FAIL perf_miss: got %b want 0", m); end
    vecs++; if (jn !== 2'b00) begin errs++; $display("FAIL perf_pulse_width: got %b want 00", jn); end
    vecs++; if (combo !== 8'd1) begin errs++; $display("FAIL perf_combo: got %0d want 1", combo); end
    vecs++; if (window_open !== 1'b0) begin errs++; $display("FAIL perf_window_fall: got %b want 0", window_open); end
  endtask

  task automatic test_early_late();
    logic [1:0] j, jn;
    logic m;
    do_reset();
    send_note();
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b01) begin errs++; $display("FAIL early_judge: got %b want 01", j); end
    send_note();
    send_ticks(4);
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b10) begin errs++; $display("FAIL late_judge: got %b want 10", j); end
    vecs++; if (combo !== 8'd2) begin errs++; $display("FAIL early_late_combo: got %0d want 2", combo); end
    vecs++; if (max_combo !== 8'd2) begin errs++; $display("FAIL early_late_max: got %0d want 2", max_combo); end
  endtask

  task automatic test_miss();
    do_reset();
    repeat (5) perfect_hit();
    vecs++; if (combo !== 8'd5) begin errs++; $display("FAIL miss_build_combo: got %0d want 5", combo); end
    send_note();
    send_ticks(5);
    vecs++; if (miss !== 1'b0 || window_open !== 1'b1) begin errs++; $display("FAIL miss_early: got miss=%b win=%b want miss=0 win=1", miss, window_open); end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    vecs++; if (miss !== 1'b1) begin errs++; $display("FAIL miss_pulse: got %b want 1", miss); end
    vecs++; if (judge !== 2'b00) begin errs++; $display("FAIL miss_judge: got %b want 00", judge); end
    vecs++; if (combo !== 8'd0) begin errs++; $display("FAIL miss_combo: got %0d want 0", combo); end
    vecs++; if (max_combo !== 8'd5) begin errs++; $display("FAIL miss_max: got %0d want 5", max_combo); end
    vecs++; if (window_open !== 1'b0) begin errs++; $display("FAIL miss_window: got %b want 0", window_open); end
    cyc();
    vecs++; if (miss !== 1'b0) begin errs++; $display("FAIL miss_pulse_width: got %b want 0", miss); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      perfect_hit();
      if (i == 255 || i == 256 || i == 260) begin
        vecs++; if (combo !== 8'd255) begin errs++; $display("FAIL sat_combo_%0d: got %0d want 255", i, combo); end
      end
    end
    vecs++; if (max_combo !== 8'd255) begin errs++; $display("FAIL sat_max: got %0d want 255", max_combo); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] j, jn;
    logic m;
    logic [7:0] c_before, mx_before;
    do_reset();
    // press and the LATE expiry tick in the same clk
    send_note();
    send_ticks(5);
    btn_raw = 1'b1;
    repeat (3) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    vecs++; if (judge !== 2'b10) begin errs++; $display("FAIL sim_late_expiry_judge: got %b want 10", judge); end
    vecs++; if (miss !== 1'b0) begin errs++; $display("FAIL sim_late_expiry_miss: got %b want 0", miss); end
    vecs++; if (combo !== 8'd1) begin errs++; $display("FAIL sim_late_expiry_combo: got %0d want 1", combo); end
    btn_raw = 1'b0;
    repeat (3) cyc();
    // note_arrive mid-window without press: old note missed, fresh EARLY window
    send_note();
    send_ticks(1);
    send_note();
    vecs++; if (miss !== 1'b1 || judge !== 2'b00) begin errs++; $display("FAIL sim_displace_miss: got miss=%b judge=%b want miss=1 judge=00", miss, judge); end
    vecs++; if (state_dbg !== ST_EARLY) begin errs++; $display("FAIL sim_displace_state: got %0d want %0d", state_dbg, ST_EARLY); end
    vecs++; if (combo !== 8'd0) begin errs++; $display("FAIL sim_displace_combo: got %0d want 0", combo); end
    send_ticks(1);
    vecs++; if (state_dbg !== ST_EARLY) begin errs++; $display("FAIL sim_reload_zcnt: got %0d want %0d", state_dbg, ST_EARLY); end
    send_ticks(1);
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b11) begin errs++; $display("FAIL sim_restart_perfect: got %b want 11", j); end
    // note_arrive + press while open: press grades the old note, new window opens
    send_note();
    send_ticks(2);
    btn_raw = 1'b1;
    repeat (3) cyc();
    note_arrive = 1'b1;
    cyc();
    note_arrive = 1'b0;
    vecs++; if (judge !== 2'b11 || miss !== 1'b0) begin errs++; $display("FAIL sim_note_press: got judge=%b miss=%b want judge=11 miss=0", judge, miss); end
    vecs++; if (window_open !== 1'b1 || state_dbg !== ST_EARLY) begin errs++; $display("FAIL sim_note_press_window: got win=%b state=%0d want win=1 state=%0d", window_open, state_dbg, ST_EARLY); end
    btn_raw = 1'b0;
    repeat (3) cyc();
    send_ticks(6);
    // stray press in IDLE
    c_before = combo;
    mx_before = max_combo;
    vecs++; if (c_before !== 8'd0 || mx_before !== 8'd2) begin errs++; $display("FAIL sim_pre_stray: got combo=%0d max=%0d want combo=0 max=2", c_before, mx_before); end
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b00 || m !== 1'b0) begin errs++; $display("FAIL stray_press_out: got judge=%b miss=%b want 00/0", j, m); end
    vecs++; if (combo !== 8'd0 || max_combo !== 8'd2 || window_open !== 1'b0) begin errs++; $display("FAIL stray_press_state: got combo=%0d max=%0d win=%b want 0/2/0", combo, max_combo, window_open); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] j, jn;
    logic m;
    do_reset();
    repeat (7) perfect_hit();
    send_note();
    send_ticks(2);
    vecs++; if (combo !== 8'd7 || state_dbg !== ST_PERFECT) begin errs++; $display("FAIL rstmid_setup: got combo=%0d state=%0d want 7/%0d", combo, state_dbg, ST_PERFECT); end
    #2;
    reset = 1'b1;
    #1;
    vecs++; if (combo !== 8'd0 || max_combo !== 8'd0 || judge !== 2'b00 || miss !== 1'b0 || window_open !== 1'b0) begin
      errs++; $display("FAIL rstmid_async: got combo=%0d max=%0d judge=%b miss=%b win=%b want all 0", combo, max_combo, judge, miss, window_open);
    end
    cyc();
    reset = 1'b0;
    cyc();
    vecs++; if (miss !== 1'b0) begin errs++; $display("FAIL rstmid_no_miss: got %b want 0", miss); end
    press_btn(j, m, jn);
    vecs++; if (j !== 2'b00 || m !== 1'b0 || combo !== 8'd0) begin errs++; $display("FAIL rstmid_press_ignored: got judge=%b miss=%b combo=%0d want 00/0/0", j, m, combo); end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_early_late();
    test_miss();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
# hit_judge

Timing-judgement block for the rhythm game. It watches one note lane and the player's button, then grades each note as early-good, perfect, late-good or miss. It produces the one-clock 2-bit judgement pulse and the 8-bit running combo that the score counter consumes. It sits between the note scheduler and the score counter, so it is the producing end of the judgement/combo interface.

## Interface
- EARLY_TICKS, 2, ticks in the early-good zone (≥1)
- PERFECT_TICKS, 2, ticks in the perfect zone (≥1)
- LATE_TICKS, 2, ticks in the late-good zone (≥1)
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high; clock clk
- tick  input  1  game-step strobe, one clk wide
- note_arrive  input  1  one-clk pulse: a note enters the hit window
- btn_raw  input  1  asynchronous player button, active-high
- judge  output  2  judgement pulse: 00 none/miss, 01 early good, 10 late good, 11 perfect
- miss  output  1  one-clk pulse: window expired unhit, or the note was displaced
- combo  output  8  consecutive hits, saturating at 255
- max_combo  output  8  highest combo since reset
- window_open  output  1  high while a note is being judged (state ≠ IDLE)

## Operation
- Judge codes match the score counter's encoding: 01/10 score the small value, 11 scores the large value, 00 adds nothing.
- Button path: a 2-flop synchronizer, then a rising-edge detector, produce `press` (one clk).
- FSM states are IDLE, EARLY, PERFECT, LATE. A down-counter `zcnt` holds the ticks remaining in the current zone.
- IDLE + note_arrive → EARLY, with zcnt=EARLY_TICKS.
- In EARLY, PERFECT and LATE, each tick decrements zcnt. When a tick arrives with zcnt=1, the FSM moves to the next zone and reloads zcnt:
  - EARLY→PERFECT, zcnt=PERFECT_TICKS
  - PERFECT→LATE, zcnt=LATE_TICKS
  - LATE→IDLE with a miss
- press in EARLY, PERFECT or LATE → judge=01, 11 or 10 respectively; the FSM then goes to IDLE.
- press in IDLE is ignored: no judge, and combo is unchanged.
- Hit: combo ← min(combo+1, 255). max_combo ← max(max_combo, new combo).
- Miss: judge stays 00, miss=1, combo ← 0, max_combo is unchanged.
- Simultaneous events in the same clk are resolved in this order:
  - press has priority over tick. A press on the expiry tick of LATE scores 10, not a miss.
  - note_arrive while the window is open: if press is also present, the press grades the old note first. Otherwise the old note is a miss. In both cases the FSM restarts in EARLY with zcnt=EARLY_TICKS.
  - note_arrive + press in IDLE: the window opens and the press is ignored.
- judge and miss are 0/00 in every cycle except the grading cycle.

## Timing
- Reset values: judge=00, miss=0, combo=0, max_combo=0, window_open=0, FSM=IDLE, zcnt=0, synchronizer flops=0.
- Reset is asynchronous and may assert mid-window. The window is abandoned with no judge and no miss pulse.
- press asserts 3 clk after btn_raw rises (2 synchronizer flops plus the edge register), given setup is met.
- judge, miss, combo and max_combo are all registered and update on the same clk edge, one clk after the press or tick event is seen.
  - The combo value visible during a judge pulse already includes that hit.
  - The score counter samples judge and combo on the following edge.
- window_open rises the clk after note_arrive and falls the clk after grading or expiry.
- Total window length is EARLY_TICKS+PERFECT_TICKS+LATE_TICKS ticks.
- tick and note_arrive are synchronous to clk; no synchronization is applied to them.

## Structure
- Shared package `rhythm_pkg`:
  - judge code constants: JUDGE_NONE, JUDGE_EARLY, JUDGE_LATE, JUDGE_PERFECT
  - FSM state typedef
  - COMBO_MAX=255
  - The score counter reuses the same judge constants.
- Sub-module `btn_sync_edge` (2-flop synchronizer plus rising-edge pulse, async reset) is instantiated once. It is reusable for other player buttons.
- The top level contains the FSM, zcnt, the combo/max_combo registers and the output registers.

## Test plan
- Perfect hit: defaults, note_arrive, 2 ticks, btn_raw rises → exactly one judge=11 pulse; combo 0→1; window_open falls.
- Early and late hits:
  - press before the first tick → judge=01.
  - press after the 4th tick → judge=10.
  - combo reaches 2 after both hits.
- Miss and reset of combo:
  - build combo=5, then let 6 ticks pass unhit → miss=1, judge=00, combo=0, max_combo=5.
- Saturation: 260 consecutive perfect hits → combo holds at 255 and max_combo=255; no wrap to 0.
- Simultaneous events:
  - press and tick on LATE expiry → judge=10, no miss.
  - note_arrive mid-window with no press → miss, new window in EARLY.
  - stray press in IDLE → no output change.
- Reset mid-window: assert reset in PERFECT with combo=7 → all outputs 0 immediately. After release, a press yields no judge until the next note_arrive.
